// File: rtl/gamma_cycle_sequencer.sv
// Sequencer for one gamma cycle of a race-logic operator: clear pulse, timed input
// spikes, then report the first rising-edge phase of the datapath output spike.
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int N_IN              = 2,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic               aclk,
  input  logic               grst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N_IN*TW-1:0] cmd_time,
  output logic               gclr,
  output logic [N_IN-1:0]    spk_out,
  input  logic               spk_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TW-1:0]      res_time,
  output logic               res_none,
  output logic               res_multi
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [TW-1:0] LAST_PHASE = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW:0]   LIVE_LIM   = (TW+1)'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);
  localparam logic [TW:0]   PW_M1      = (TW+1)'(PULSE_WIDTH - 1);

  state_t               state;
  logic [TW-1:0]        phase;
  logic                 prev_in;
  logic                 seen;
  logic [N_IN*TW-1:0]   times;
  logic [TW:0]          next_phase;
  logic [N_IN-1:0]      lane_next;
  logic                 rise;
  logic                 last_phase;

  // Spike outputs are registered, so lanes are evaluated for the phase about to start.
  assign next_phase = (state == RUN) ? ({1'b0, phase} + 1'b1) : '0;
  assign rise       = spk_in & ~prev_in;
  assign last_phase = (phase == LAST_PHASE);

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_lane
      logic [TW:0] t;
      assign t = {1'b0, times[gi*TW +: TW]};
      assign lane_next[gi] = (t < LIVE_LIM) && (next_phase >= t) && (next_phase <= t + PW_M1);
    end
  endgenerate

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      gclr      <= 1'b1;
      spk_out   <= '0;
      res_valid <= 1'b0;
      res_time  <= '0;
      res_none  <= 1'b0;
      res_multi <= 1'b0;
      phase     <= '0;
      prev_in   <= 1'b0;
      seen      <= 1'b0;
      times     <= '0;
    end else begin
      case (state)
        IDLE: begin
          gclr      <= 1'b0;
          res_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            times     <= cmd_time;
            cmd_ready <= 1'b0;
            gclr      <= 1'b1;
            spk_out   <= '0;
            prev_in   <= 1'b0;
            seen      <= 1'b0;
            res_time  <= '0;
            res_none  <= 1'b0;
            res_multi <= 1'b0;
            state     <= CLEAR;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        CLEAR: begin
          gclr    <= 1'b0;
          phase   <= '0;
          spk_out <= lane_next;
          state   <= RUN;
        end
        RUN: begin
          prev_in <= spk_in;
          if (rise) begin
            if (!seen) begin
              res_time <= phase;
              seen     <= 1'b1;
            end else begin
              res_multi <= 1'b1;
            end
          end
          if (last_phase) begin
            spk_out   <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
            if (!seen && !rise) begin
              res_none <= 1'b1;
              res_time <= LAST_PHASE;
            end
          end else begin
            phase   <= phase + 1'b1;
            spk_out <= lane_next;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Directed bench for gamma_cycle_sequencer (G=16, PW=8, two lanes).
module tb_gamma_cycle_sequencer;
  localparam int G  = 16;
  localparam int PW = 8;
  localparam int N  = 2;
  localparam int TW = 4;

  logic              aclk = 1'b0;
  logic              grst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [N*TW-1:0]   cmd_time;
  logic              gclr;
  logic [N-1:0]      spk_out;
  logic              spk_in;
  logic              res_valid;
  logic              res_ready;
  logic [TW-1:0]     res_time;
  logic              res_none;
  logic              res_multi;

  int n_tests = 0;
  int n_fail  = 0;

  gamma_cycle_sequencer #(
    .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .N_IN(N), .TW(TW)
  ) dut (
    .aclk(aclk), .grst(grst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_time(cmd_time), .gclr(gclr), .spk_out(spk_out), .spk_in(spk_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_time(res_time),
    .res_none(res_none), .res_multi(res_multi)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_spk(input int t0, input int t1, input int p);
    logic [N-1:0] v;
    int t[2];
    t[0] = t0;
    t[1] = t1;
    for (int i = 0; i < N; i++)
      v[i] = (t[i] < G - PW) && (p >= t[i]) && (p <= t[i] + PW - 1);
    return v;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  // Accepts a command, walks all RUN phases applying pat (bit p = spk_in at phase p),
  // then checks the result, optionally stalling res_ready with cmd_valid held high.
  task automatic run_cmd(input string name, input int t0, input int t1, input logic [15:0] pat,
                         input int e_time, input logic e_none, input logic e_multi, input int hold);
    wait_ready();
    cmd_time  = {4'(t1), 4'(t0)};
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk({name, "_gclr_T1"}, gclr, 1'b1);
    chk({name, "_spk_T1"}, spk_out, '0);
    chk({name, "_rdy_T1"}, cmd_ready, 1'b0);
    step();
    chk({name, "_gclr_p0"}, gclr, 1'b0);
    for (int p = 0; p < G; p++) begin
      spk_in = pat[p];
      chk($sformatf("%s_spk_p%0d", name, p), spk_out, exp_spk(t0, t1, p));
      chk($sformatf("%s_vld_p%0d", name, p), res_valid, 1'b0);
      step();
    end
    spk_in = 1'b0;
    chk({name, "_valid"}, res_valid, 1'b1);
    chk({name, "_time"}, res_time, e_time);
    chk({name, "_none"}, res_none, e_none);
    chk({name, "_multi"}, res_multi, e_multi);
    chk({name, "_spk_done"}, spk_out, '0);
    if (hold > 0) begin
      cmd_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        step();
        chk($sformatf("%s_hold%0d_valid", name, h), res_valid, 1'b1);
        chk($sformatf("%s_hold%0d_time", name, h), res_time, e_time);
        chk($sformatf("%s_hold%0d_flags", name, h), {res_none, res_multi}, {e_none, e_multi});
        chk($sformatf("%s_hold%0d_rdy", name, h), cmd_ready, 1'b0);
        chk($sformatf("%s_hold%0d_gclr", name, h), gclr, 1'b0);
      end
      cmd_valid = 1'b0;
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({name, "_vld_after"}, res_valid, 1'b0);
    chk({name, "_rdy_after"}, cmd_ready, 1'b1);
    $display("[TB] %s t0=%0d t1=%0d -> time=%0d none=%0d multi=%0d", name, t0, t1,
             res_time, res_none, res_multi);
  endtask

  initial begin
    grst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_time  = '0;
    spk_in    = 1'b0;
    res_ready = 1'b0;
    #12;
    chk("rst_gclr", gclr, 1'b1);
    chk("rst_rdy", cmd_ready, 1'b0);
    chk("rst_vld", res_valid, 1'b0);
    chk("rst_spk", spk_out, '0);
    chk("rst_fields", {res_time, res_none, res_multi}, '0);
    grst = 1'b0;
    step();
    chk("rel_rdy", cmd_ready, 1'b1);
    chk("rel_gclr", gclr, 1'b0);

    run_cmd("basic",   2, 5, 16'h0000, 15, 1'b1, 1'b0, 0);
    run_cmd("lt",      2, 5, 16'h03FC,  2, 1'b0, 1'b0, 0);
    run_cmd("inf",     2, 9, 16'h0000, 15, 1'b1, 1'b0, 0);
    run_cmd("multi",   1, 7, 16'hF80F,  0, 1'b0, 1'b1, 0);
    run_cmd("last",    3, 3, 16'h8000, 15, 1'b0, 1'b0, 0);
    run_cmd("stall",   0, 7, 16'h0780,  7, 1'b0, 1'b0, 5);

    // Abort mid-cycle with an asynchronous reset at phase 6.
    wait_ready();
    cmd_time  = {4'(4), 4'(2)};
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("abort_spk_pre", spk_out, exp_spk(2, 4, 6));
    #2 grst = 1'b1;
    #1;
    chk("abort_spk", spk_out, '0);
    chk("abort_gclr", gclr, 1'b1);
    chk("abort_vld", res_valid, 1'b0);
    chk("abort_rdy", cmd_ready, 1'b0);
    step();
    grst = 1'b0;
    step();
    chk("abort_rel_rdy", cmd_ready, 1'b1);
    run_cmd("post_rst", 4, 0, 16'h0030, 4, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
